// File: rtl/sigmoid_unit.sv
// sigmoid_unit: logistic activation for signed Q16.16 inputs.
// Three-stage, enable-gated pipeline: magnitude/saturation, chord
// interpolation over 32 segments of width 0.25 on |x| in [0,8), then
// reflection through sigma(-x) = 1 - sigma(x). Output is unsigned Q16.16.
module sigmoid_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam logic [16:0] ONE = 17'h10000;

  // Knot values A_k = round(sigma(k/4) * 2^16), k = 0..32.
  function automatic logic [16:0] coef(input logic [5:0] idx);
    logic [16:0] a;
    case (idx)
      6'd0:    a = 17'd32768;
      6'd1:    a = 17'd36843;
      6'd2:    a = 17'd40793;
      6'd3:    a = 17'd44511;
      6'd4:    a = 17'd47911;
      6'd5:    a = 17'd50941;
      6'd6:    a = 17'd53581;
      6'd7:    a = 17'd55834;
      6'd8:    a = 17'd57724;
      6'd9:    a = 17'd59287;
      6'd10:   a = 17'd60565;
      6'd11:   a = 17'd61598;
      6'd12:   a = 17'd62428;
      6'd13:   a = 17'd63090;
      6'd14:   a = 17'd63615;
      6'd15:   a = 17'd64030;
      6'd16:   a = 17'd64357;
      6'd17:   a = 17'd64614;
      6'd18:   a = 17'd64816;
      6'd19:   a = 17'd64974;
      6'd20:   a = 17'd65097;
      6'd21:   a = 17'd65194;
      6'd22:   a = 17'd65269;
      6'd23:   a = 17'd65328;
      6'd24:   a = 17'd65374;
      6'd25:   a = 17'd65410;
      6'd26:   a = 17'd65438;
      6'd27:   a = 17'd65459;
      6'd28:   a = 17'd65476;
      6'd29:   a = 17'd65489;
      6'd30:   a = 17'd65500;
      6'd31:   a = 17'd65508;
      default: a = 17'd65514;
    endcase
    return a;
  endfunction

  // Stage 1 registers
  logic        s1;
  logic [31:0] m1;
  logic        sat1;

  // Stage 2 registers
  logic        s2;
  logic [16:0] y2;

  // Combinational helpers
  logic [31:0] mag;
  logic [4:0]  seg;
  logic [13:0] frac;
  logic [16:0] a_lo;
  logic [16:0] a_hi;
  logic [16:0] delta;
  logic [30:0] prod;
  logic [16:0] y_pos;

  // Absolute value of the input; 0x80000000 stays 0x80000000 and saturates.
  always_comb begin
    mag = data_in[31] ? (~data_in + 32'd1) : data_in;
  end

  // Chord interpolation inside the segment selected by m1[18:14].
  always_comb begin
    seg   = m1[18:14];
    frac  = m1[13:0];
    a_lo  = coef({1'b0, seg});
    a_hi  = coef({1'b0, seg} + 6'd1);
    delta = a_hi - a_lo;
    prod  = {14'b0, delta} * {17'b0, frac};
    y_pos = sat1 ? ONE : (a_lo + prod[30:14]);
  end

  // Stage 1: sign, magnitude and saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      m1   <= '0;
      sat1 <= 1'b0;
    end else if (en) begin
      s1   <= data_in[31];
      m1   <= mag;
      sat1 <= |mag[31:19];
    end
  end

  // Stage 2: positive-half sigmoid value and carried sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= 1'b0;
      y2 <= '0;
    end else if (en) begin
      s2 <= s1;
      y2 <= y_pos;
    end
  end

  // Stage 3: reflect negative inputs and register the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (en) begin
      data_out <= {15'b0, (s2 ? (ONE - y2) : y2)};
    end
  end

endmodule

// File: tb/tb_sigmoid_unit.sv
// Testbench for sigmoid_unit: randomized stimulus against a reference
// built from the logistic function itself, with a queue-based model of
// the enable-gated 3-deep pipeline.
module tb_sigmoid_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int unsigned n_checks;
  int unsigned n_errors;

  int          coef_tab [0:32];
  logic [31:0] hist[$];   // inputs accepted on enabled edges since reset
  logic [31:0] outs[$];   // outs[i] is the output observed for hist[i]

  sigmoid_unit dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (x=0x%08h)", tag, obs, exp_v, data_in);
    end
  endtask

  function automatic real true_sigmoid(input logic [31:0] x);
    real xr;
    xr = real'($signed(x)) / 65536.0;
    return 65536.0 / (1.0 + $exp(-xr));
  endfunction

  // Chord approximation of sigma(x) between knots at multiples of 0.25.
  function automatic logic [31:0] ref_sigmoid(input logic [31:0] x);
    longint sx;
    longint mag;
    longint y;
    int     k;
    longint f;
    sx  = longint'($signed(x));
    mag = (sx < 0) ? -sx : sx;
    if (mag >= 64'd524288) begin
      y = 65536;
    end else begin
      k = int'(mag / 16384);
      f = mag % 16384;
      y = coef_tab[k] + ((coef_tab[k+1] - coef_tab[k]) * f) / 16384;
    end
    if (x[31]) y = 65536 - y;
    return 32'(y);
  endfunction

  // Absolute error against the real sigmoid, 0 when inside the 66 LSB bound.
  function automatic int acc_excess(input logic [31:0] x, input logic [31:0] y);
    real err;
    err = real'(y) - true_sigmoid(x);
    if (err < 0.0) err = -err;
    return (err > 66.0) ? ($rtoi(err) + 1) : 0;
  endfunction

  task automatic do_reset(input int unsigned cycles);
    rst     = 1'b1;
    en      = 1'b1;
    data_in = 32'h0003_0000;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset_out", data_out, 32'h0);
    end
    rst = 1'b0;
    hist.delete();
    outs.delete();
  endtask

  // Apply one cycle of stimulus and check the output after the edge.
  task automatic step(input string tag, input logic [31:0] x, input logic e, input bit chk_acc);
    logic [31:0] exp_v;
    data_in = x;
    en      = e;
    @(posedge clk);
    #1;
    if (e) hist.push_back(x);
    if (hist.size() >= 3) begin
      exp_v = ref_sigmoid(hist[hist.size() - 3]);
      check(tag, data_out, exp_v);
      if (e) outs.push_back(data_out);
      if (chk_acc) check({tag, "_acc"}, acc_excess(hist[hist.size() - 3], data_out), 0);
    end
  endtask

  task automatic hold_value(input string tag, input logic [31:0] x, input logic [31:0] exp_v);
    for (int unsigned i = 0; i < 4; i++) step(tag, x, 1'b1, 1'b0);
    check({tag, "_const"}, data_out, exp_v);
  endtask

  logic [31:0] key_in  [0:7];
  logic [31:0] key_out [0:7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    en       = 1'b0;
    data_in  = '0;
    for (int k = 0; k <= 32; k++)
      coef_tab[k] = $rtoi(65536.0 / (1.0 + $exp(-real'(k) / 4.0)) + 0.5);

    key_in[0] = 32'h0000_0000; key_out[0] = 32'h0000_8000;
    key_in[1] = 32'h0001_0000; key_out[1] = 32'h0000_BB27;
    key_in[2] = 32'hFFFF_0000; key_out[2] = 32'h0000_44D9;
    key_in[3] = 32'h0002_0000; key_out[3] = 32'h0000_E17C;
    key_in[4] = 32'h000A_0000; key_out[4] = 32'h0001_0000;
    key_in[5] = 32'hFFF6_0000; key_out[5] = 32'h0000_0000;
    key_in[6] = 32'h8000_0000; key_out[6] = 32'h0000_0000;
    key_in[7] = 32'h7FFF_FFFF; key_out[7] = 32'h0001_0000;

    @(negedge clk);

    // Reset behaviour, then sigma(3) three edges after release.
    do_reset(2);
    for (int unsigned i = 0; i < 3; i++) step("post_reset", 32'h0003_0000, 1'b1, 1'b0);
    check("post_reset_acc", acc_excess(32'h0003_0000, data_out), 0);

    // Key points and saturation.
    for (int i = 0; i < 8; i++) hold_value("key", key_in[i], key_out[i]);

    // Streaming: a new random sample every cycle.
    for (int unsigned i = 0; i < 64; i++) step("stream", $urandom, 1'b1, 1'b1);

    // Enable hold: accept x=1.0, then 10 idle cycles with garbage input.
    step("hold_in", 32'h0001_0000, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 10; i++) step("hold", $urandom, 1'b0, 1'b0);
    step("hold_resume", $urandom, 1'b1, 1'b0);
    step("hold_resume", $urandom, 1'b1, 1'b0);
    check("hold_bb27", data_out, 32'h0000_BB27);

    // Random en toggling, then a mid-stream reset.
    for (int unsigned i = 0; i < 200; i++) step("en_toggle", $urandom, 1'($urandom_range(0, 1)), 1'b0);
    do_reset(1);
    for (int unsigned i = 0; i < 6; i++) step("after_reset2", $urandom, 1'b1, 1'b1);

    // Random sweep of +x / -x pairs with integer part 0..5.
    begin
      int unsigned base;
      logic [31:0] x;
      base = hist.size();
      for (int unsigned i = 0; i < 10000; i++) begin
        x = (32'($urandom_range(0, 5)) << 16) | ($urandom & 32'h0000_FFFF);
        step("sweep", x, 1'b1, 1'b1);
        step("sweep_neg", -x, 1'b1, 1'b1);
      end
      for (int unsigned i = 0; i < 3; i++) step("sweep_flush", 32'h0, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 10000; i++)
        check("symmetry", outs[base + 2*i] + outs[base + 2*i + 1], 32'h0001_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
